// File: rtl/snake_tile_map_builder.sv
// Per-frame builder of a double-buffered snake tile-occupancy map; the front buffer serves one lookup per pixel.
// Optional head-on-body collision flag is built when SNAKE_SELF_COLLIDE_EN is defined.
module snake_tile_map_builder #(
  parameter int unsigned GRID_W    = 10,
  parameter int unsigned GRID_H    = 10,
  parameter int unsigned MAX_SEG   = 100,
  parameter int unsigned SEG_IDX_W = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_start,
  output logic                 seg_req,
  output logic [SEG_IDX_W-1:0] seg_idx,
  input  logic                 seg_ack,
  input  logic [31:0]          seg_x,
  input  logic [31:0]          seg_y,
  input  logic [31:0]          food_x,
  input  logic [31:0]          food_y,
  input  logic [7:0]           tile_x,
  input  logic [7:0]           tile_y,
  output logic [1:0]           tile_state,
  output logic                 build_busy,
  output logic                 overrun,
  output logic                 bad_coord,
  output logic                 collide
);
  localparam int unsigned CELLS  = GRID_W * GRID_H;
  localparam int unsigned CELL_W = $clog2(CELLS);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_REQ   = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_FOOD  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [1:0] T_EMPTY = 2'd0;
  localparam logic [1:0] T_BODY  = 2'd1;
  localparam logic [1:0] T_HEAD  = 2'd2;
  localparam logic [1:0] T_FOOD  = 2'd3;

  function automatic logic in_grid(input logic [31:0] x, input logic [31:0] y);
    return (x < 32'(GRID_W)) && (y < 32'(GRID_H));
  endfunction

  function automatic logic [CELL_W-1:0] cell_of(input logic [31:0] x, input logic [31:0] y);
    return CELL_W'(y * 32'(GRID_W) + x);
  endfunction

  logic [2:0]        state, state_nx;
  logic              front_sel, back_sel;
  logic [1:0]        map_q [2][CELLS];
  logic [31:0]       food_x_q, food_y_q;
  logic              seg_term, seg_in, seg_done, seg_write, food_in, look_in;
  logic              in_build, busy_nx;
  logic [CELL_W-1:0] seg_cell, food_cell, look_cell;
  logic [1:0]        seg_cur, food_cur;

  assign back_sel  = ~front_sel;
  assign seg_term  = (seg_x == '1) || (seg_y == '1);
  assign seg_in    = in_grid(seg_x, seg_y);
  assign seg_done  = seg_term || (seg_idx == SEG_IDX_W'(MAX_SEG - 1));
  assign seg_write = (state == S_WAIT) && seg_ack && !seg_term && seg_in;
  assign seg_cell  = cell_of(seg_x, seg_y);
  assign seg_cur   = map_q[back_sel][seg_cell];
  assign food_in   = in_grid(food_x_q, food_y_q);
  assign food_cell = cell_of(food_x_q, food_y_q);
  assign food_cur  = map_q[back_sel][food_cell];
  assign look_in   = in_grid(32'(tile_x), 32'(tile_y));
  assign look_cell = cell_of(32'(tile_x), 32'(tile_y));
  assign in_build  = (state == S_CLEAR) || (state == S_REQ) || (state == S_WAIT) || (state == S_FOOD);
  assign busy_nx   = (state_nx == S_CLEAR) || (state_nx == S_REQ) ||
                     (state_nx == S_WAIT) || (state_nx == S_FOOD);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE: if (frame_start) state_nx = S_CLEAR;
      S_CLEAR:        state_nx = S_REQ;
      S_REQ:          state_nx = S_WAIT;
      S_WAIT:         if (seg_ack) state_nx = seg_done ? S_FOOD : S_REQ;
      S_FOOD:         state_nx = S_DONE;
      default:        state_nx = S_IDLE;
    endcase
  end

  // Map buffers, segment port, lookup and sticky flags
  always_ff @(posedge clk) begin
    if (!reset) begin
      front_sel  <= 1'b0;
      seg_req    <= 1'b0;
      seg_idx    <= '0;
      tile_state <= T_EMPTY;
      build_busy <= 1'b0;
      overrun    <= 1'b0;
      bad_coord  <= 1'b0;
      food_x_q   <= '0;
      food_y_q   <= '0;
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < int'(CELLS); i++) map_q[b][i] <= T_EMPTY;
    end else begin
      tile_state <= look_in ? map_q[front_sel][look_cell] : T_EMPTY;
      build_busy <= busy_nx;
      if (frame_start && in_build) overrun <= 1'b1;
      case (state)
        S_IDLE, S_DONE: begin
          if (frame_start) begin
            food_x_q <= food_x;
            food_y_q <= food_y;
            if (state == S_DONE) front_sel <= ~front_sel;
          end
        end
        S_CLEAR: begin
          for (int i = 0; i < int'(CELLS); i++) map_q[back_sel][i] <= T_EMPTY;
          seg_idx <= '0;
        end
        S_REQ: seg_req <= 1'b1;
        S_WAIT: begin
          if (seg_ack) begin
            seg_req <= 1'b0;
            if (!seg_term && !seg_in) bad_coord <= 1'b1;
            // Head is always first after the clear; later body writes must not hide it
            if (seg_write) begin
              if (seg_idx == '0)          map_q[back_sel][seg_cell] <= T_HEAD;
              else if (seg_cur != T_HEAD) map_q[back_sel][seg_cell] <= T_BODY;
            end
            if (!seg_done) seg_idx <= seg_idx + SEG_IDX_W'(1);
          end
        end
        S_FOOD: begin
          if (!food_in)                  bad_coord <= 1'b1;
          else if (food_cur == T_EMPTY)  map_q[back_sel][food_cell] <= T_FOOD;
        end
        default: ;
      endcase
    end
  end

`ifdef SNAKE_SELF_COLLIDE_EN
  logic build_col;

  // Collision accumulates during the build and is published at the swap
  always_ff @(posedge clk) begin
    if (!reset) begin
      build_col <= 1'b0;
      collide   <= 1'b0;
    end else begin
      if (state == S_CLEAR) build_col <= 1'b0;
      else if (seg_write && ((seg_idx == '0) ? (seg_cur == T_BODY) : (seg_cur == T_HEAD)))
        build_col <= 1'b1;
      if ((state == S_DONE) && frame_start) collide <= build_col;
    end
  end
`else
  assign collide = 1'b0;
`endif

endmodule

// File: tb/tb_snake_tile_map_builder.sv
// Randomized bench for snake_tile_map_builder against a frame-level map model.
module tb_snake_tile_map_builder;
  localparam int GW = 10;
  localparam int GH = 10;
  localparam int MS = 100;
  localparam int IW = 7;
  localparam int BUILD_LIMIT = 6000;
`ifdef SNAKE_SELF_COLLIDE_EN
  localparam bit EXP_COLLIDE = 1'b1;
`else
  localparam bit EXP_COLLIDE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          frame_start;
  logic          seg_req;
  logic [IW-1:0] seg_idx;
  logic          seg_ack;
  logic [31:0]   seg_x, seg_y, food_x, food_y;
  logic [7:0]    tile_x, tile_y;
  logic [1:0]    tile_state;
  logic          build_busy, overrun, bad_coord, collide;

  snake_tile_map_builder #(.GRID_W(GW), .GRID_H(GH), .MAX_SEG(MS), .SEG_IDX_W(IW)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .seg_req(seg_req), .seg_idx(seg_idx), .seg_ack(seg_ack),
    .seg_x(seg_x), .seg_y(seg_y), .food_x(food_x), .food_y(food_y),
    .tile_x(tile_x), .tile_y(tile_y), .tile_state(tile_state),
    .build_busy(build_busy), .overrun(overrun), .bad_coord(bad_coord), .collide(collide)
  );

  always #5 clk = ~clk;

  logic [31:0] lx [128];
  logic [31:0] ly [128];
  int ack_delay = 1;
  bit resp_en = 1'b1;
  int late_req = 0;
  int late_done;

  int m_front [GW*GH];
  int m_built [GW*GH];
  bit m_pending, m_built_col, exp_col, exp_bad;
  int vec_cnt = 0;
  int err_cnt = 0;

  // Segment memory model: answers each request after ack_delay cycles
  initial begin
    int cnt;
    cnt = 0; late_done = 0; seg_ack = 1'b0; seg_x = '0; seg_y = '0;
    forever begin
      @(negedge clk);
      seg_ack = 1'b0;
      if (late_req != late_done) begin
        seg_ack = 1'b1; seg_x = 32'd1; seg_y = 32'd1; late_done = late_req; cnt = 0;
      end else if (resp_en && seg_req) begin
        cnt++;
        if (cnt >= ack_delay) begin
          seg_ack = 1'b1; seg_x = lx[seg_idx]; seg_y = ly[seg_idx]; cnt = 0;
        end
      end else cnt = 0;
    end
  end

  function automatic void model_build(input logic [31:0] fx, input logic [31:0] fy);
    int c;
    for (int k = 0; k < GW*GH; k++) m_built[k] = 0;
    m_built_col = 1'b0;
    for (int i = 0; i < MS; i++) begin
      if (lx[i] == 32'hFFFF_FFFF || ly[i] == 32'hFFFF_FFFF) break;
      if (lx[i] < 32'(GW) && ly[i] < 32'(GH)) begin
        c = int'(ly[i]) * GW + int'(lx[i]);
        if (i == 0) begin
          if (m_built[c] == 1) m_built_col = 1'b1;
          m_built[c] = 2;
        end else if (m_built[c] == 2) m_built_col = 1'b1;
        else m_built[c] = 1;
      end else exp_bad = 1'b1;
    end
    if (fx < 32'(GW) && fy < 32'(GH)) begin
      c = int'(fy) * GW + int'(fx);
      if (m_built[c] == 0) m_built[c] = 3;
    end else exp_bad = 1'b1;
    if (!EXP_COLLIDE) m_built_col = 1'b0;
  endfunction

  task automatic apply_reset();
    reset = 1'b0; frame_start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < GW*GH; k++) m_front[k] = 0;
    m_pending = 1'b0; exp_col = 1'b0; exp_bad = 1'b0;
  endtask

  task automatic set_list(input int n);
    for (int i = n; i < 128; i++) begin lx[i] = 32'hFFFF_FFFF; ly[i] = 32'hFFFF_FFFF; end
  endtask

  task automatic start_frame(input logic [31:0] fx, input logic [31:0] fy);
    food_x = fx; food_y = fy;
    if (m_pending) begin m_front = m_built; exp_col = m_built_col; end
    model_build(fx, fy);
    m_pending = 1'b1;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    vec_cnt++;
    if (build_busy !== 1'b1) begin err_cnt++; $display("FAIL busy_rise got %b want 1", build_busy); end
  endtask

  task automatic wait_build();
    int t;
    t = 0;
    while (build_busy === 1'b1 && t < BUILD_LIMIT) begin @(negedge clk); t++; end
    vec_cnt++;
    if (t >= BUILD_LIMIT) begin err_cnt++; $display("FAIL build_timeout got %0d cycles want <%0d", t, BUILD_LIMIT); end
  endtask

  task automatic do_frame(input logic [31:0] fx, input logic [31:0] fy);
    start_frame(fx, fy);
    wait_build();
  endtask

  task automatic read_tile(input int x, input int y, output logic [1:0] st);
    tile_x = 8'(x); tile_y = 8'(y);
    @(negedge clk);
    st = tile_state;
  endtask

  task automatic test_reset();
    logic [1:0] st;
    apply_reset();
    vec_cnt++;
    if ({seg_req, build_busy, overrun, bad_coord, collide, tile_state} !== 7'b0) begin
      err_cnt++; $display("FAIL reset_outputs got %b want 0000000", {seg_req, build_busy, overrun, bad_coord, collide, tile_state});
    end
    lx[0] = 32'd1; ly[0] = 32'd1; set_list(1);
    do_frame(32'd5, 32'd5);
    for (int k = 0; k < 2; k++) begin
      read_tile(k == 0 ? 1 : 5, k == 0 ? 1 : 5, st);
      vec_cnt++;
      if (st !== 2'd0) begin err_cnt++; $display("FAIL first_frame_noswap got %0d want 0", st); end
    end
  endtask

  task automatic test_basic();
    logic [1:0] st, ex;
    int ax[6] = '{2, 2, 2, 7, 0, 255};
    int ay[6] = '{3, 4, 5, 7, 0, 255};
    logic [1:0] aw[6] = '{2'd2, 2'd1, 2'd1, 2'd3, 2'd0, 2'd0};
    ack_delay = 1;
    lx[0] = 32'd2; ly[0] = 32'd3; lx[1] = 32'd2; ly[1] = 32'd4; lx[2] = 32'd2; ly[2] = 32'd5; set_list(3);
    do_frame(32'd7, 32'd7);
    do_frame(32'd7, 32'd7);
    for (int k = 0; k < 6; k++) begin
      read_tile(ax[k], ay[k], st);
      vec_cnt++;
      if (st !== aw[k]) begin err_cnt++; $display("FAIL basic_tile(%0d,%0d) got %0d want %0d", ax[k], ay[k], st, aw[k]); end
    end
    for (int y = 0; y <= GH; y++) for (int x = 0; x <= GW; x++) begin
      read_tile(x, y, st);
      ex = (x < GW && y < GH) ? 2'(m_front[y*GW+x]) : 2'd0;
      vec_cnt++;
      if (st !== ex) begin err_cnt++; $display("FAIL basic_scan(%0d,%0d) got %0d want %0d", x, y, st, ex); end
    end
    vec_cnt++;
    if ({overrun, bad_coord} !== 2'b00) begin err_cnt++; $display("FAIL basic_flags got %b want 00", {overrun, bad_coord}); end
  endtask

  task automatic test_food_hidden();
    logic [1:0] st, ex;
    int foods;
    foods = 0;
    do_frame(32'd2, 32'd4);
    do_frame(32'd2, 32'd4);
    for (int y = 0; y < GH; y++) for (int x = 0; x < GW; x++) begin
      read_tile(x, y, st);
      ex = 2'(m_front[y*GW+x]);
      if (st === 2'd3) foods++;
      vec_cnt++;
      if (st !== ex) begin err_cnt++; $display("FAIL food_scan(%0d,%0d) got %0d want %0d", x, y, st, ex); end
    end
    read_tile(2, 4, st);
    vec_cnt++;
    if (st !== 2'd1) begin err_cnt++; $display("FAIL food_under_body got %0d want 1", st); end
    vec_cnt++;
    if (foods !== 0) begin err_cnt++; $display("FAIL food_count got %0d want 0", foods); end
  endtask

  task automatic test_bad_coord();
    logic [1:0] st, ex;
    lx[0] = 32'd10; ly[0] = 32'd0; lx[1] = 32'd3; ly[1] = 32'd3; lx[2] = 32'd3; ly[2] = 32'd4; set_list(3);
    do_frame(32'd5, 32'd5);
    vec_cnt++;
    if (bad_coord !== 1'b1) begin err_cnt++; $display("FAIL bad_coord_set got %b want 1", bad_coord); end
    do_frame(32'd5, 32'd5);
    for (int y = 0; y <= GH; y++) for (int x = 0; x <= GW; x++) begin
      read_tile(x, y, st);
      ex = (x < GW && y < GH) ? 2'(m_front[y*GW+x]) : 2'd0;
      vec_cnt++;
      if (st !== ex) begin err_cnt++; $display("FAIL bad_scan(%0d,%0d) got %0d want %0d", x, y, st, ex); end
    end
    read_tile(3, 4, st);
    vec_cnt++;
    if (st !== 2'd1) begin err_cnt++; $display("FAIL bad_rest_mapped got %0d want 1", st); end
  endtask

  task automatic test_collide();
    logic [1:0] st;
    lx[0] = 32'd4; ly[0] = 32'd4; lx[1] = 32'd4; ly[1] = 32'd5; lx[2] = 32'd4; ly[2] = 32'd4; set_list(3);
    do_frame(32'd0, 32'd9);
    do_frame(32'd0, 32'd9);
    vec_cnt++;
    if (collide !== EXP_COLLIDE) begin err_cnt++; $display("FAIL collide got %b want %b", collide, EXP_COLLIDE); end
    read_tile(4, 4, st);
    vec_cnt++;
    if (st !== 2'd2) begin err_cnt++; $display("FAIL collide_head got %0d want 2", st); end
  endtask

  task automatic test_random();
    logic [1:0] st, ex;
    int n;
    logic [31:0] fx, fy;
    apply_reset();
    for (int it = 0; it < 8; it++) begin
      n = int'($urandom_range(1, 15));
      for (int i = 0; i < n; i++) begin
        lx[i] = ($urandom_range(0, 11) == 0) ? 32'($urandom_range(10, 300)) : 32'($urandom_range(0, GW - 1));
        ly[i] = ($urandom_range(0, 11) == 0) ? 32'hFFFF_FFFE : 32'($urandom_range(0, GH - 1));
      end
      set_list(n);
      if (it[0]) lx[n] = 32'($urandom_range(0, 9));
      fx = ($urandom_range(0, 7) == 0) ? 32'd12 : 32'($urandom_range(0, GW - 1));
      fy = 32'($urandom_range(0, GH - 1));
      ack_delay = int'($urandom_range(1, 4));
      do_frame(fx, fy);
      for (int y = 0; y <= GH; y++) for (int x = 0; x <= GW; x++) begin
        read_tile(x, y, st);
        ex = (x < GW && y < GH) ? 2'(m_front[y*GW+x]) : 2'd0;
        vec_cnt++;
        if (st !== ex) begin err_cnt++; $display("FAIL rand%0d_scan(%0d,%0d) got %0d want %0d", it, x, y, st, ex); end
      end
      vec_cnt++;
      if ({bad_coord, collide} !== {exp_bad, exp_col}) begin
        err_cnt++; $display("FAIL rand%0d_flags got %b want %b", it, {bad_coord, collide}, {exp_bad, exp_col});
      end
    end
  endtask

  task automatic test_overrun();
    logic [1:0] st, ex;
    for (int i = 0; i < MS; i++) begin lx[i] = 32'($urandom_range(0, GW - 1)); ly[i] = 32'($urandom_range(0, GH - 1)); end
    set_list(MS);
    ack_delay = 20;
    start_frame(32'd9, 32'd0);
    repeat (500) @(negedge clk);
    vec_cnt++;
    if (build_busy !== 1'b1) begin err_cnt++; $display("FAIL ovr_still_busy got %b want 1", build_busy); end
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    vec_cnt++;
    if (overrun !== 1'b1) begin err_cnt++; $display("FAIL overrun got %b want 1", overrun); end
    for (int y = 0; y < GH; y++) for (int x = 0; x < GW; x++) begin
      read_tile(x, y, st);
      ex = 2'(m_front[y*GW+x]);
      vec_cnt++;
      if (st !== ex) begin err_cnt++; $display("FAIL ovr_noswap(%0d,%0d) got %0d want %0d", x, y, st, ex); end
    end
    wait_build();
    ack_delay = 1;
    lx[0] = 32'd0; ly[0] = 32'd0; set_list(1);
    do_frame(32'd1, 32'd1);
    for (int y = 0; y < GH; y++) for (int x = 0; x < GW; x++) begin
      read_tile(x, y, st);
      ex = 2'(m_front[y*GW+x]);
      vec_cnt++;
      if (st !== ex) begin err_cnt++; $display("FAIL ovr_swap(%0d,%0d) got %0d want %0d", x, y, st, ex); end
    end
    vec_cnt++;
    if (collide !== exp_col) begin err_cnt++; $display("FAIL ovr_collide got %b want %b", collide, exp_col); end
  endtask

  task automatic test_reset_mid_wait();
    logic [1:0] st;
    resp_en = 1'b0;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (4) @(negedge clk);
    vec_cnt++;
    if (seg_req !== 1'b1) begin err_cnt++; $display("FAIL mid_wait_req got %b want 1", seg_req); end
    apply_reset();
    vec_cnt++;
    if ({seg_req, build_busy, overrun, bad_coord, collide, tile_state} !== 7'b0) begin
      err_cnt++; $display("FAIL mid_reset_outputs got %b want 0000000", {seg_req, build_busy, overrun, bad_coord, collide, tile_state});
    end
    late_req++;
    repeat (3) @(negedge clk);
    vec_cnt++;
    if ({seg_req, build_busy} !== 2'b00) begin err_cnt++; $display("FAIL late_ack_ignored got %b want 00", {seg_req, build_busy}); end
    for (int y = 0; y < GH; y++) for (int x = 0; x < GW; x++) begin
      read_tile(x, y, st);
      vec_cnt++;
      if (st !== 2'd0) begin err_cnt++; $display("FAIL mid_reset_tile(%0d,%0d) got %0d want 0", x, y, st); end
    end
    resp_en = 1'b1;
    lx[0] = 32'd6; ly[0] = 32'd6; set_list(1);
    do_frame(32'd8, 32'd8);
    do_frame(32'd8, 32'd8);
    read_tile(6, 6, st);
    vec_cnt++;
    if (st !== 2'd2) begin err_cnt++; $display("FAIL recover_head got %0d want 2", st); end
  endtask

  initial begin
    reset = 1'b1; frame_start = 1'b0; food_x = '0; food_y = '0; tile_x = '0; tile_y = '0;
    set_list(0);
    @(negedge clk);
    test_reset();
    test_basic();
    test_food_hidden();
    test_bad_coord();
    test_collide();
    test_random();
    test_overrun();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
